// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer: phase encodings,
// key codes and the helper that turns a configured duration into the value
// loaded into the 8-bit seconds counter.
package wash_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_WASH  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_RINSE = 3'd5;
    localparam logic [2:0] ST_SPIN  = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    localparam logic [2:0] KEY_NONE   = 3'd0;
    localparam logic [2:0] KEY_START  = 3'd1;
    localparam logic [2:0] KEY_LOW    = 3'd2;
    localparam logic [2:0] KEY_HIGH   = 3'd3;
    localparam logic [2:0] KEY_PAUSE  = 3'd4;
    localparam logic [2:0] KEY_RESUME = 3'd5;

    // A zero duration still has to last one tick, and anything beyond the
    // counter range saturates at 255 seconds.
    function automatic logic [7:0] dur8(input int t);
        if (t <= 0)
            return 8'd1;
        else if (t > 255)
            return 8'd255;
        else
            return t[7:0];
    endfunction

endpackage

// File: rtl/wash_ctrl_sec_tick.sv
// One-second prescaler. Counts 0..DIV-1 while enabled and flags the last
// count as the tick; a clear restarts the second from zero.
module sec_tick #(
    parameter int DIV = 20000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Prescaler count: clear wins, otherwise advance and wrap while enabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/wash_ctrl.sv
// Washing-machine program sequencer: level select, fill, wash, drain,
// optional rinse loops, spin and done, driven by key-code change events.
// phase exports the state register directly for display and debug.
module wash_ctrl
    import wash_pkg::*;
#(
    parameter int TICK_DIV  = 20000000,
    parameter int T_SEL     = 3,
    parameter int T_FILL_LO = 10,
    parameter int T_FILL_HI = 20,
    parameter int T_WASH    = 60,
    parameter int T_RINSE   = 30,
    parameter int T_DRAIN   = 15,
    parameter int T_SPIN    = 40,
    parameter int T_DONE    = 5,
    parameter int RINSE_CNT = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] key_value,
    output logic       valve_in,
    output logic       valve_out,
    output logic       motor_wash,
    output logic       motor_spin,
    output logic       paused,
    output logic       done,
    output logic       level_hi,
    output logic [2:0] phase,
    output logic [7:0] remain_sec
);
    localparam logic [7:0] D_SEL     = dur8(T_SEL);
    localparam logic [7:0] D_FILL_LO = dur8(T_FILL_LO);
    localparam logic [7:0] D_FILL_HI = dur8(T_FILL_HI);
    localparam logic [7:0] D_WASH    = dur8(T_WASH);
    localparam logic [7:0] D_RINSE   = dur8(T_RINSE);
    localparam logic [7:0] D_DRAIN   = dur8(T_DRAIN);
    localparam logic [7:0] D_SPIN    = dur8(T_SPIN);
    localparam logic [7:0] D_DONE    = dur8(T_DONE);
    localparam logic [1:0] RCNT      = (RINSE_CNT < 0) ? 2'd0 :
                                       (RINSE_CNT > 3) ? 2'd3 : 2'(RINSE_CNT);

    logic [2:0] state, n_state, key_d;
    logic [1:0] rinse_left, n_rleft;
    logic       rinse_phase, n_rphase, sel_seen, n_seen, n_paused, n_level;
    logic [7:0] n_remain, fill_dur;
    logic       ev, abort_ev, pause_ev, resume_ev, pausable, running;
    logic       restart, tick, pre_clr, pre_en;

    assign ev        = (key_value != key_d);
    assign pausable  = (state >= ST_FILL) && (state <= ST_SPIN);
    assign abort_ev  = ev && (key_value == KEY_NONE);
    assign pause_ev  = ev && (key_value == KEY_PAUSE) && pausable && !paused;
    assign resume_ev = ev && (key_value == KEY_RESUME) && paused;
    assign running   = (state >= ST_FILL) || ((state == ST_SEL) && sel_seen);
    assign fill_dur  = level_hi ? D_FILL_HI : D_FILL_LO;

    // The prescaler restarts with every phase, and holds on the pause edge,
    // while paused and on the resume edge so timing picks up where it stopped.
    assign pre_clr = (n_state != state) || restart || (state == ST_IDLE);
    assign pre_en  = running && !paused && !pause_ev;

    sec_tick #(.DIV(TICK_DIV)) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    // Next-state logic; priority is abort, then pause/resume, then timing.
    always_comb begin
        n_state  = state;
        n_paused = paused;
        n_level  = level_hi;
        n_remain = remain_sec;
        n_rleft  = rinse_left;
        n_rphase = rinse_phase;
        n_seen   = sel_seen;
        restart  = 1'b0;
        if (abort_ev) begin
            n_state  = ST_IDLE;
            n_paused = 1'b0;
            n_level  = 1'b0;
            n_remain = 8'd0;
            n_rleft  = 2'd0;
            n_rphase = 1'b0;
            n_seen   = 1'b0;
        end else if (pause_ev) begin
            n_paused = 1'b1;
        end else if (resume_ev) begin
            n_paused = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ev && (key_value == KEY_START)) begin
                        n_state  = ST_SEL;
                        n_level  = 1'b0;
                        n_remain = 8'd0;
                        n_seen   = 1'b0;
                    end
                end
                ST_SEL: begin
                    if (ev && ((key_value == KEY_LOW) || (key_value == KEY_HIGH))) begin
                        n_level  = (key_value == KEY_HIGH);
                        n_remain = D_SEL;
                        n_seen   = 1'b1;
                        restart  = 1'b1;
                    end else if (tick) begin
                        if (remain_sec <= 8'd1) begin
                            n_state  = ST_FILL;
                            n_remain = fill_dur;
                            n_rleft  = RCNT;
                            n_rphase = 1'b0;
                        end else begin
                            n_remain = remain_sec - 8'd1;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (remain_sec > 8'd1) begin
                            n_remain = remain_sec - 8'd1;
                        end else begin
                            case (state)
                                ST_FILL: begin
                                    n_state  = rinse_phase ? ST_RINSE : ST_WASH;
                                    n_remain = rinse_phase ? D_RINSE : D_WASH;
                                end
                                ST_WASH, ST_RINSE: begin
                                    n_state  = ST_DRAIN;
                                    n_remain = D_DRAIN;
                                end
                                ST_DRAIN: begin
                                    if (rinse_left != 2'd0) begin
                                        n_state  = ST_FILL;
                                        n_remain = fill_dur;
                                        n_rleft  = rinse_left - 2'd1;
                                        n_rphase = 1'b1;
                                    end else begin
                                        n_state  = ST_SPIN;
                                        n_remain = D_SPIN;
                                    end
                                end
                                ST_SPIN: begin
                                    n_state  = ST_DONE;
                                    n_remain = D_DONE;
                                end
                                default: begin
                                    // DONE finished: IDLE shows all-zero outputs.
                                    n_state  = ST_IDLE;
                                    n_remain = 8'd0;
                                    n_level  = 1'b0;
                                    n_rphase = 1'b0;
                                    n_seen   = 1'b0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Program state registers, including the key history used for events.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            key_d       <= KEY_NONE;
            paused      <= 1'b0;
            level_hi    <= 1'b0;
            remain_sec  <= 8'd0;
            rinse_left  <= 2'd0;
            rinse_phase <= 1'b0;
            sel_seen    <= 1'b0;
        end else begin
            state       <= n_state;
            key_d       <= key_value;
            paused      <= n_paused;
            level_hi    <= n_level;
            remain_sec  <= n_remain;
            rinse_left  <= n_rleft;
            rinse_phase <= n_rphase;
            sel_seen    <= n_seen;
        end
    end

    // Actuators follow the registered phase and are all off while paused,
    // so only one group is ever active and the two valves never overlap.
    assign valve_in   = (state == ST_FILL) && !paused;
    assign valve_out  = ((state == ST_DRAIN) || (state == ST_SPIN)) && !paused;
    assign motor_wash = ((state == ST_WASH) || (state == ST_RINSE)) && !paused;
    assign motor_spin = (state == ST_SPIN) && !paused;
    assign done       = (state == ST_DONE);
    assign phase      = state;

endmodule

// File: tb/tb_wash_ctrl.sv
// Bench for wash_ctrl: two instances (one rinse loop / no rinse loop, different
// durations) share reset and key input and are compared every cycle against a
// program-plan model that counts active cycles spent in each phase.
module tb_wash_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] key_value = 3'd0;

    logic a_valve_in, a_valve_out, a_motor_wash, a_motor_spin, a_paused, a_done, a_level_hi;
    logic b_valve_in, b_valve_out, b_motor_wash, b_motor_spin, b_paused, b_done, b_level_hi;
    logic [2:0] a_phase, b_phase;
    logic [7:0] a_remain_sec, b_remain_sec;
    logic [17:0] a_vec, b_vec;

    int checks = 0;
    int errors = 0;

    // clock
    always #5 CLK = ~CLK;

    wash_ctrl #(
        .TICK_DIV(4), .T_SEL(2), .T_FILL_LO(2), .T_FILL_HI(2), .T_WASH(2),
        .T_RINSE(2), .T_DRAIN(2), .T_SPIN(2), .T_DONE(2), .RINSE_CNT(1)
    ) dut_a (
        .CLK(CLK), .RST_N(RST_N), .key_value(key_value),
        .valve_in(a_valve_in), .valve_out(a_valve_out), .motor_wash(a_motor_wash),
        .motor_spin(a_motor_spin), .paused(a_paused), .done(a_done),
        .level_hi(a_level_hi), .phase(a_phase), .remain_sec(a_remain_sec)
    );

    wash_ctrl #(
        .TICK_DIV(3), .T_SEL(3), .T_FILL_LO(1), .T_FILL_HI(4), .T_WASH(3),
        .T_RINSE(2), .T_DRAIN(2), .T_SPIN(5), .T_DONE(0), .RINSE_CNT(0)
    ) dut_b (
        .CLK(CLK), .RST_N(RST_N), .key_value(key_value),
        .valve_in(b_valve_in), .valve_out(b_valve_out), .motor_wash(b_motor_wash),
        .motor_spin(b_motor_spin), .paused(b_paused), .done(b_done),
        .level_hi(b_level_hi), .phase(b_phase), .remain_sec(b_remain_sec)
    );

    assign a_vec = {a_valve_in, a_valve_out, a_motor_wash, a_motor_spin, a_paused,
                    a_done, a_level_hi, a_phase, a_remain_sec};
    assign b_vec = {b_valve_in, b_valve_out, b_motor_wash, b_motor_spin, b_paused,
                    b_done, b_level_hi, b_phase, b_remain_sec};

    // ---------------- behavioural model ----------------
    // duration table: 0 sel, 1 fill lo, 2 fill hi, 3 wash, 4 rinse, 5 drain, 6 spin, 7 done
    int m_div[2]    = '{4, 3};
    int m_rcnt[2]   = '{1, 0};
    int m_tab[2][8] = '{'{2, 2, 2, 2, 2, 2, 2, 2}, '{3, 1, 4, 3, 2, 2, 5, 0}};

    int         m_ph[2];
    int         m_el[2];
    bit         m_pz[2];
    bit         m_lv[2];
    bit         m_seen[2];
    int         m_plan[2][16];
    int         m_pi[2];
    logic [2:0] m_keyd;

    function automatic int eff(input int t);
        if (t <= 0) return 1;
        if (t > 255) return 255;
        return t;
    endfunction

    function automatic int m_dur(input int i);
        case (m_ph[i])
            1: return eff(m_tab[i][0]);
            2: return eff(m_lv[i] ? m_tab[i][2] : m_tab[i][1]);
            3: return eff(m_tab[i][3]);
            5: return eff(m_tab[i][4]);
            4: return eff(m_tab[i][5]);
            6: return eff(m_tab[i][6]);
            7: return eff(m_tab[i][7]);
            default: return 0;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec(input int i);
        int         ph;
        bit         pz;
        int         rem;
        logic [2:0] p3;
        logic [7:0] r8;
        ph = m_ph[i];
        pz = m_pz[i];
        if (ph == 0 || (ph == 1 && !m_seen[i])) rem = 0;
        else rem = m_dur(i) - m_el[i] / m_div[i];
        p3 = ph[2:0];
        r8 = 8'(rem);
        return {ph == 2 && !pz, (ph == 4 || ph == 6) && !pz, (ph == 3 || ph == 5) && !pz,
                ph == 6 && !pz, pz, ph == 7, m_lv[i], p3, r8};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_el[i] = 0; m_pz[i] = 0; m_lv[i] = 0; m_seen[i] = 0; m_pi[i] = 0;
        end
        m_keyd = 3'd0;
    endtask

    // Whole program laid out as a list of phases once selection finishes.
    task automatic m_next(input int i);
        int n;
        if (m_ph[i] == 1) begin
            n = 0;
            m_plan[i][n++] = 2; m_plan[i][n++] = 3; m_plan[i][n++] = 4;
            for (int r = 0; r < m_rcnt[i]; r++) begin
                m_plan[i][n++] = 2; m_plan[i][n++] = 5; m_plan[i][n++] = 4;
            end
            m_plan[i][n++] = 6; m_plan[i][n++] = 7; m_plan[i][n++] = 0;
            m_pi[i] = 0;
        end else begin
            m_pi[i]++;
        end
        m_ph[i] = m_plan[i][m_pi[i]];
        m_el[i] = 0;
        if (m_ph[i] == 0) begin
            m_lv[i] = 0; m_seen[i] = 0;
        end
    endtask

    task automatic m_time(input int i);
        m_el[i]++;
        if (m_el[i] >= m_dur(i) * m_div[i]) m_next(i);
    endtask

    task automatic m_step(input logic [2:0] key);
        bit ev;
        ev = (key != m_keyd);
        for (int i = 0; i < 2; i++) begin
            if (ev && key == 3'd0) begin
                m_ph[i] = 0; m_pz[i] = 0; m_lv[i] = 0; m_seen[i] = 0; m_el[i] = 0;
            end else if (ev && key == 3'd4 && m_ph[i] >= 2 && m_ph[i] <= 6 && !m_pz[i]) begin
                m_pz[i] = 1;
            end else if (ev && key == 3'd5 && m_pz[i]) begin
                m_pz[i] = 0;
            end else if (m_ph[i] == 0) begin
                if (ev && key == 3'd1) begin
                    m_ph[i] = 1; m_lv[i] = 0; m_seen[i] = 0; m_el[i] = 0;
                end
            end else if (m_ph[i] == 1) begin
                if (ev && (key == 3'd2 || key == 3'd3)) begin
                    m_lv[i] = (key == 3'd3); m_seen[i] = 1; m_el[i] = 0;
                end else if (m_seen[i]) begin
                    m_time(i);
                end
            end else if (!m_pz[i]) begin
                m_time(i);
            end
        end
        m_keyd = key;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) m_reset();
            else m_step(key_value);
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare and monitors ----------------
    int a_vin_cnt = 0, a_done_cnt = 0, b_vin_cnt = 0, b_done_cnt = 0, b_rinse_seen = 0;
    int qa[$];
    int qb[$];
    logic [2:0] a_last = 3'd0, b_last = 3'd0;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                chk("cyc_a", a_vec, exp_vec(0));
                chk("cyc_b", b_vec, exp_vec(1));
                if (a_valve_in) a_vin_cnt++;
                if (a_done) a_done_cnt++;
                if (b_valve_in) b_vin_cnt++;
                if (b_done) b_done_cnt++;
                if (b_phase == 3'd5) b_rinse_seen++;
                if (a_phase != a_last) qa.push_back(int'(a_phase));
                if (b_phase != b_last) qb.push_back(int'(b_phase));
                a_last = a_phase;
                b_last = b_phase;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_key(input logic [2:0] k);
        @(posedge CLK);
        #2 key_value = k;
    endtask

    // Move to the negedge after the edge that samples the last key written.
    task automatic to_effect();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_a(input int ph, input int rem, input int budget, input string name);
        int n;
        n = 0;
        while (!(a_phase == 3'(ph) && (rem < 0 || a_remain_sec == 8'(rem))) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(a_phase == 3'd0 && b_phase == 3'd0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    int exp_a_seq[10] = '{1, 2, 3, 4, 2, 5, 4, 6, 7, 0};
    int exp_b_seq[7]  = '{1, 2, 3, 4, 6, 7, 0};

    initial begin
        int qa0, qb0, va0, vb0, da0, db0, r;

        // reset
        RST_N = 1'b0;
        key_value = 3'd0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        chk("reset_a", a_vec, 18'd0);
        chk("reset_b", b_vec, 18'd0);

        // full program with high level: 0 -> 1 -> 3, then hold
        qa0 = qa.size(); qb0 = qb.size();
        va0 = a_vin_cnt; vb0 = b_vin_cnt; da0 = a_done_cnt; db0 = b_done_cnt;
        set_key(3'd1);
        set_key(3'd3);
        to_effect();
        chk_int("sel_remain_a", int'(a_remain_sec), 2);
        chk_int("sel_level_a", int'(a_level_hi), 1);
        wait_a(2, -1, 40, "reach_fill_a");
        chk_int("fill_level_a", int'(a_level_hi), 1);
        wait_idle(300, "main_run_idle");
        chk_int("seq_len_a", qa.size() - qa0, 10);
        for (int k = 0; k < 10; k++)
            if (qa0 + k < qa.size()) chk_int("seq_a", qa[qa0 + k], exp_a_seq[k]);
        chk_int("seq_len_b", qb.size() - qb0, 7);
        for (int k = 0; k < 7; k++)
            if (qb0 + k < qb.size()) chk_int("seq_b", qb[qb0 + k], exp_b_seq[k]);
        chk_int("fill_cycles_a", a_vin_cnt - va0, 16);
        chk_int("done_cycles_a", a_done_cnt - da0, 8);
        chk_int("fill_cycles_b", b_vin_cnt - vb0, 12);
        chk_int("done_cycles_b", b_done_cnt - db0, 3);

        // level select: low then high inside the window restarts the timer
        set_key(3'd0);
        set_key(3'd1);
        set_key(3'd2);
        repeat (3) @(negedge CLK);
        set_key(3'd3);
        to_effect();
        chk_int("reselect_remain_a", int'(a_remain_sec), 2);
        chk_int("reselect_remain_b", int'(b_remain_sec), 3);
        chk_int("reselect_level_a", int'(a_level_hi), 1);
        wait_idle(300, "reselect_idle");

        // low level only
        vb0 = b_vin_cnt; va0 = a_vin_cnt;
        set_key(3'd0);
        set_key(3'd1);
        set_key(3'd2);
        to_effect();
        chk_int("low_level_a", int'(a_level_hi), 0);
        wait_idle(300, "low_idle");
        chk_int("low_fill_cycles_b", b_vin_cnt - vb0, 3);
        chk_int("low_fill_cycles_a", a_vin_cnt - va0, 16);

        // pause in WASH with one second left and the prescaler at 2
        set_key(3'd0);
        set_key(3'd1);
        set_key(3'd3);
        wait_a(3, 1, 60, "reach_wash_last_sec");
        @(posedge CLK);
        @(posedge CLK);
        #2 key_value = 3'd4;
        @(posedge CLK);
        @(negedge CLK);
        chk_int("pause_motor", int'(a_motor_wash), 0);
        chk_int("pause_flag", int'(a_paused), 1);
        repeat (50) @(negedge CLK);
        chk_int("frozen_phase", int'(a_phase), 3);
        chk_int("frozen_remain", int'(a_remain_sec), 1);
        chk_int("frozen_paused", int'(a_paused), 1);
        @(posedge CLK);
        #2 key_value = 3'd5;
        @(posedge CLK);
        @(negedge CLK);
        chk_int("resume_motor", int'(a_motor_wash), 1);
        chk_int("resume_paused", int'(a_paused), 0);
        @(negedge CLK);
        chk_int("resume_plus1_phase", int'(a_phase), 3);
        @(negedge CLK);
        chk_int("resume_plus2_phase", int'(a_phase), 4);

        // abort during a paused SPIN
        wait_a(6, -1, 200, "reach_spin");
        set_key(3'd4);
        to_effect();
        chk_int("spin_paused", int'(a_paused), 1);
        repeat (3) @(negedge CLK);
        set_key(3'd0);
        to_effect();
        chk("abort_a", a_vec, 18'd0);

        // asynchronous reset in the middle of FILL
        set_key(3'd1);
        set_key(3'd2);
        wait_a(2, -1, 60, "reach_fill_rst");
        @(posedge CLK);
        #3;
        chk_int("pre_rst_valve", int'(a_valve_in), 1);
        RST_N = 1'b0;
        #1;
        chk("async_rst_a", a_vec, 18'd0);
        chk("async_rst_b", b_vec, 18'd0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        chk_int("post_rst_idle", int'(a_phase), 0);
        set_key(3'd1);
        to_effect();
        chk_int("post_rst_start", int'(a_phase), 1);
        set_key(3'd0);

        // randomized key traffic, checked cycle by cycle against the model
        repeat (1500) begin
            @(posedge CLK);
            #2;
            r = int'($urandom_range(0, 99));
            if (r < 1) key_value = 3'd0;
            else if (r < 13) key_value = 3'($urandom_range(1, 5));
        end
        repeat (2) @(negedge CLK);

        chk_int("no_rinse_b", b_rinse_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
